// File: rtl/im_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : im_uart_loader
// Purpose  : Instruction-memory loader. Turns framed, checksummed UART byte
//            streams into word writes on the instruction-ROM write port, and
//            provides a hardware fill of the whole memory with FILL_VAL.
//            Frame: SYNC, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, N*BYTES data, CSUM.
// Ports    : clk, rstn (async, active-low)
//            enable              - low aborts any activity, returns to idle
//            clear_req           - one-cycle request to fill memory
//            rx_valid, rx_byte   - byte strobe and data from the UART receiver
//            mem_we/addr/wdata   - registered memory write port
//            busy                - frame or clear in progress
//            done, err_csum, err_len, err_timeout - sticky frame status
//            words_loaded        - words written by the current/last frame
// Revision : 1.0 - initial release
// ============================================================================
module im_uart_loader #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 11,
  parameter int unsigned       DEPTH      = 2048,
  parameter logic [7:0]        SYNC       = 8'hA5,
  parameter logic [DATA_W-1:0] FILL_VAL   = DATA_W'(32'h0000_0013),
  parameter bit                BIG_ENDIAN = 1'b0,
  parameter int unsigned       TIMEOUT    = 1000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              clear_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_csum,
  output logic              err_len,
  output logic              err_timeout,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  // The timer only ever holds 0..TIMEOUT-1.
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Wide enough for base + 16-bit count without overflow.
  localparam int unsigned CHK_W = ((ADDR_W > 16) ? ADDR_W : 16) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_A_LO, S_A_HI, S_C_LO, S_C_HI, S_DATA, S_CHK, S_CLEAR
  } state_t;

  state_t             state_q, state_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_csum_q, err_csum_d;
  logic               err_len_q, err_len_d;
  logic               err_timeout_q, err_timeout_d;
  logic [ADDR_W:0]    words_loaded_q, words_loaded_d;
  logic [7:0]         addr_lo_q, addr_lo_d;
  logic [7:0]         cnt_lo_q, cnt_lo_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [7:0]         sum_q, sum_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [15:0]        w_cnt;
  logic [CHK_W-1:0]   w_end;
  logic [7:0]         w_sum;
  logic               w_last;
  logic [IDX_W-1:0]   w_pos;
  logic [DATA_W-1:0]  w_word;

  always_comb begin
    state_d        = state_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    busy_d         = busy_q;
    done_d         = done_q;
    err_csum_d     = err_csum_q;
    err_len_d      = err_len_q;
    err_timeout_d  = err_timeout_q;
    words_loaded_d = words_loaded_q;
    addr_lo_d      = addr_lo_q;
    cnt_lo_d       = cnt_lo_q;
    base_d         = base_q;
    cnt_d          = cnt_q;
    word_d         = word_q;
    byte_idx_d     = byte_idx_q;
    sum_d          = sum_q;
    timer_d        = timer_q;

    w_cnt  = {rx_byte, cnt_lo_q};
    w_end  = CHK_W'(base_q) + CHK_W'(w_cnt);
    w_sum  = sum_q + rx_byte;
    w_last = (byte_idx_q == IDX_W'(BYTES - 1));
    // Byte lane for the incoming byte inside the word being assembled.
    w_pos  = BIG_ENDIAN ? (IDX_W'(BYTES - 1) - byte_idx_q) : byte_idx_q;
    w_word = word_q;
    for (int b = 0; b < int'(BYTES); b++) begin
      if (w_pos == IDX_W'(b)) w_word[b*8 +: 8] = rx_byte;
    end

    if (!enable) begin
      // Abort: back to idle silently; mem_we_d already defaults low.
      state_d = S_IDLE;
      busy_d  = 1'b0;
      timer_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clear_req) begin
            // clear_req has priority over a byte arriving in the same cycle.
            state_d       = S_CLEAR;
            busy_d        = 1'b1;
            done_d        = 1'b0;
            err_csum_d    = 1'b0;
            err_len_d     = 1'b0;
            err_timeout_d = 1'b0;
            mem_we_d      = 1'b1;
            mem_addr_d    = '0;
            mem_wdata_d   = FILL_VAL;
          end else if (rx_valid && (rx_byte == SYNC)) begin
            state_d        = S_A_LO;
            busy_d         = 1'b1;
            done_d         = 1'b0;
            err_csum_d     = 1'b0;
            err_len_d      = 1'b0;
            err_timeout_d  = 1'b0;
            words_loaded_d = '0;
            sum_d          = '0;
            timer_d        = '0;
          end
        end

        S_CLEAR: begin
          if (mem_addr_q == ADDR_W'(DEPTH - 1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            mem_we_d   = 1'b1;
            mem_addr_d = mem_addr_q + 1'b1;
          end
        end

        default: begin
          if (rx_valid) begin
            timer_d = '0;
            sum_d   = w_sum;
            case (state_q)
              S_A_LO: begin
                addr_lo_d = rx_byte;
                state_d   = S_A_HI;
              end
              S_A_HI: begin
                base_d  = ADDR_W'({rx_byte, addr_lo_q});
                state_d = S_C_LO;
              end
              S_C_LO: begin
                cnt_lo_d = rx_byte;
                state_d  = S_C_HI;
              end
              S_C_HI: begin
                if ((w_cnt == 16'd0) || (w_end > CHK_W'(DEPTH))) begin
                  err_len_d = 1'b1;
                  busy_d    = 1'b0;
                  state_d   = S_IDLE;
                end else begin
                  cnt_d      = (ADDR_W+1)'(w_cnt);
                  byte_idx_d = '0;
                  state_d    = S_DATA;
                end
              end
              S_DATA: begin
                word_d = w_word;
                if (w_last) begin
                  byte_idx_d     = '0;
                  mem_we_d       = 1'b1;
                  mem_addr_d     = base_q + words_loaded_q[ADDR_W-1:0];
                  mem_wdata_d    = w_word;
                  words_loaded_d = words_loaded_q + 1'b1;
                  if ((words_loaded_q + 1'b1) == cnt_q) state_d = S_CHK;
                end else begin
                  byte_idx_d = byte_idx_q + 1'b1;
                end
              end
              S_CHK: begin
                // Sum over everything after SYNC, CSUM included, must be zero.
                if (w_sum == 8'd0) done_d = 1'b1;
                else               err_csum_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
              end
              default: state_d = S_IDLE;
            endcase
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            err_timeout_d = 1'b1;
            busy_d        = 1'b0;
            state_d       = S_IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_csum_q     <= 1'b0;
      err_len_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
      words_loaded_q <= '0;
      addr_lo_q      <= '0;
      cnt_lo_q       <= '0;
      base_q         <= '0;
      cnt_q          <= '0;
      word_q         <= '0;
      byte_idx_q     <= '0;
      sum_q          <= '0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_csum_q     <= err_csum_d;
      err_len_q      <= err_len_d;
      err_timeout_q  <= err_timeout_d;
      words_loaded_q <= words_loaded_d;
      addr_lo_q      <= addr_lo_d;
      cnt_lo_q       <= cnt_lo_d;
      base_q         <= base_d;
      cnt_q          <= cnt_d;
      word_q         <= word_d;
      byte_idx_q     <= byte_idx_d;
      sum_q          <= sum_d;
      timer_q        <= timer_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_csum     = err_csum_q;
  assign err_len      = err_len_q;
  assign err_timeout  = err_timeout_q;
  assign words_loaded = words_loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_im_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_uart_loader
// Purpose  : Self-checking bench for im_uart_loader. Two instances (little-
//            and big-endian) share the stimulus; expected writes and flags
//            come from a frame model built from the byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_im_uart_loader;
  localparam int DEPTH = 2048;
  localparam int TMO   = 100;
  localparam logic [7:0] SYNC_B = 8'hA5;

  logic clk = 1'b0;
  logic rstn, enable, clear_req, rx_valid;
  logic [7:0] rx_byte;
  logic le_we, be_we, le_busy, be_busy, le_done, be_done;
  logic le_ecs, be_ecs, le_elen, be_elen, le_eto, be_eto;
  logic [10:0] le_addr, be_addr;
  logic [31:0] le_wdata, be_wdata;
  logic [11:0] le_wl, be_wl;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] cyc = 32'd0;

  typedef struct packed { logic [10:0] a; logic [31:0] d; logic [31:0] c; } wr_t;
  wr_t le_q[$];
  wr_t be_q[$];
  logic [7:0] pay_q[$];

  im_uart_loader #(.DATA_W(32), .ADDR_W(11), .DEPTH(DEPTH), .SYNC(8'hA5),
    .FILL_VAL(32'h13), .BIG_ENDIAN(1'b0), .TIMEOUT(TMO)) u_le (
    .clk(clk), .rstn(rstn), .enable(enable), .clear_req(clear_req),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .mem_we(le_we), .mem_addr(le_addr),
    .mem_wdata(le_wdata), .busy(le_busy), .done(le_done), .err_csum(le_ecs),
    .err_len(le_elen), .err_timeout(le_eto), .words_loaded(le_wl));

  im_uart_loader #(.DATA_W(32), .ADDR_W(11), .DEPTH(DEPTH), .SYNC(8'hA5),
    .FILL_VAL(32'h13), .BIG_ENDIAN(1'b1), .TIMEOUT(TMO)) u_be (
    .clk(clk), .rstn(rstn), .enable(enable), .clear_req(clear_req),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .mem_we(be_we), .mem_addr(be_addr),
    .mem_wdata(be_wdata), .busy(be_busy), .done(be_done), .err_csum(be_ecs),
    .err_len(be_elen), .err_timeout(be_eto), .words_loaded(be_wl));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Write logger: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (le_we) le_q.push_back({le_addr, le_wdata, cyc});
    if (be_we) be_q.push_back({be_addr, be_wdata, cyc});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, output logic [31:0] at);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    at       = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // Sends one frame and checks flags and writes of both instances against the
  // frame model. Payload comes from pay_q when non-empty, else random.
  task automatic run_frame(input int base, input int n, input bit bad_csum,
                           input int max_gap, input string name);
    logic [7:0]  sum, b;
    logic [7:0]  hdr[4];
    logic [31:0] t, w_le, w_be;
    logic [31:0] wcyc[$];
    logic [31:0] exp_le[$];
    logic [31:0] exp_be[$];
    logic [4:0]  exp_f;
    bit          len_bad, busy_pre;
    int          bad;
    wr_t         g0;
    len_bad = (n == 0) || (base + n > DEPTH);
    le_q.delete();
    be_q.delete();
    hdr[0] = base[7:0];
    hdr[1] = {5'($urandom), base[10:8]};
    hdr[2] = n[7:0];
    hdr[3] = n[15:8];
    sum = 8'h00;
    send_byte(SYNC_B, t);
    idle($urandom_range(0, max_gap));
    for (int i = 0; i < 4; i++) begin
      send_byte(hdr[i], t);
      sum = sum + hdr[i];
      if (i < 3) idle($urandom_range(0, max_gap));
    end
    if (len_bad) begin
      @(negedge clk);
      rx_valid = 1'b0;
      n_checks++;
      if ({le_busy, le_done, le_elen, be_elen} !== 4'b0011)
        $display("FAIL %s len_flags: busy/done/err_len/be_err_len=%b required 0011",
                 name, {le_busy, le_done, le_elen, be_elen});
      else n_pass++;
      idle(3);
      #1;
      n_checks++;
      if (le_q.size() != 0 || be_q.size() != 0)
        $display("FAIL %s len_nowrite: writes le=%0d be=%0d required 0", name, le_q.size(), be_q.size());
      else n_pass++;
      return;
    end
    idle($urandom_range(0, max_gap));
    for (int k = 0; k < n; k++) begin
      w_le = 32'd0;
      w_be = 32'd0;
      for (int j = 0; j < 4; j++) begin
        b = (pay_q.size() > 0) ? pay_q[(k*4 + j) % pay_q.size()] : 8'($urandom);
        w_le[j*8 +: 8]     = b;
        w_be[(3-j)*8 +: 8] = b;
        send_byte(b, t);
        sum = sum + b;
        if (j == 3) wcyc.push_back(t);
        idle($urandom_range(0, max_gap));
      end
      exp_le.push_back(w_le);
      exp_be.push_back(w_be);
    end
    @(negedge clk);
    busy_pre = le_busy && be_busy;
    rx_valid = 1'b1;
    rx_byte  = (8'h00 - sum) + (bad_csum ? 8'h01 : 8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    exp_f = {1'b0, ~bad_csum, bad_csum, 2'b00};
    n_checks++;
    if (!busy_pre) $display("FAIL %s busy_in_frame: busy=0 required 1", name);
    else n_pass++;
    n_checks++;
    if ({le_busy, le_done, le_ecs, le_elen, le_eto} !== exp_f ||
        {be_busy, be_done, be_ecs, be_elen, be_eto} !== exp_f)
      $display("FAIL %s flags: le busy/done/csum/len/tmo=%b be=%b required %b", name,
               {le_busy, le_done, le_ecs, le_elen, le_eto},
               {be_busy, be_done, be_ecs, be_elen, be_eto}, exp_f);
    else n_pass++;
    n_checks++;
    if (le_wl !== 12'(n) || be_wl !== 12'(n))
      $display("FAIL %s words_loaded: le=%0d be=%0d required %0d", name, le_wl, be_wl, n);
    else n_pass++;
    @(negedge clk);
    #1;
    bad = 0;
    if (le_q.size() != n) bad = 1;
    else for (int k = 0; k < n; k++)
      if (le_q[k].a !== 11'(base + k) || le_q[k].d !== exp_le[k] || le_q[k].c !== wcyc[k] + 32'd1) bad = 1;
    g0 = (le_q.size() > 0) ? le_q[0] : '0;
    n_checks++;
    if (bad != 0)
      $display("FAIL %s le_writes: %0d writes first a=%h d=%h c=%0d, required %0d first a=%h d=%h c=%0d",
               name, le_q.size(), g0.a, g0.d, g0.c, n, 11'(base), exp_le[0], wcyc[0] + 32'd1);
    else n_pass++;
    bad = 0;
    if (be_q.size() != n) bad = 1;
    else for (int k = 0; k < n; k++)
      if (be_q[k].a !== 11'(base + k) || be_q[k].d !== exp_be[k] || be_q[k].c !== wcyc[k] + 32'd1) bad = 1;
    g0 = (be_q.size() > 0) ? be_q[0] : '0;
    n_checks++;
    if (bad != 0)
      $display("FAIL %s be_writes: %0d writes first a=%h d=%h c=%0d, required %0d first a=%h d=%h c=%0d",
               name, be_q.size(), g0.a, g0.d, g0.c, n, 11'(base), exp_be[0], wcyc[0] + 32'd1);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [31:0] t;
    rstn = 1'b0; enable = 1'b0; clear_req = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({le_we, le_busy, le_done, le_ecs, le_elen, le_eto, be_we, be_busy} !== 8'd0 ||
        le_addr !== 11'd0 || le_wdata !== 32'd0 || le_wl !== 12'd0)
      $display("FAIL reset_state: we/busy/flags=%b addr=%h data=%h wl=%0d required all zero",
               {le_we, le_busy, le_done, le_ecs, le_elen, le_eto, be_we, be_busy}, le_addr, le_wdata, le_wl);
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    send_byte(SYNC_B, t);
    idle(1);
    n_checks++;
    if (le_busy !== 1'b0) $display("FAIL sync_while_disabled: busy=%b required 0", le_busy);
    else n_pass++;
    enable = 1'b1;
    idle(1);
  endtask

  task automatic test_spec_frame();
    pay_q = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    run_frame(16, 2, 1'b0, 1, "spec_frame");
    n_checks++;
    if (le_q.size() != 2 || le_q[0].a !== 11'h010 || le_q[0].d !== 32'h00500093 ||
        le_q[1].a !== 11'h011 || le_q[1].d !== 32'h00100113)
      $display("FAIL spec_words: %0d writes a0=%h d0=%h required a0=010 d0=00500093 a1=011 d1=00100113",
               le_q.size(), (le_q.size() > 0) ? le_q[0].a : 11'h0, (le_q.size() > 0) ? le_q[0].d : 32'h0);
    else n_pass++;
    run_frame(16, 2, 1'b1, 1, "bad_csum");
    pay_q.delete();
  endtask

  task automatic test_len();
    run_frame(2046, 2, 1'b0, 0, "len_edge_ok");
    run_frame(2047, 1, 1'b0, 1, "len_last_word");
    run_frame(0, 4096, 1'b0, 1, "len_too_big");
    run_frame(100, 0, 1'b0, 1, "len_zero");
    run_frame(2047, 2, 1'b0, 0, "len_over_end");
  endtask

  task automatic test_clear();
    int bad = 0;
    int first_i = -1;
    logic [42:0] first_v = '0;
    le_q.delete();
    be_q.delete();
    @(negedge clk);
    clear_req = 1'b1; rx_valid = 1'b1; rx_byte = SYNC_B;
    @(negedge clk);
    clear_req = 1'b0; rx_valid = 1'b0;
    n_checks++;
    if ({le_done, le_ecs, le_elen, le_eto} !== 4'b0000)
      $display("FAIL clear_flags: done/csum/len/tmo=%b required 0000", {le_done, le_ecs, le_elen, le_eto});
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      if (le_we !== 1'b1 || le_addr !== 11'(i) || le_wdata !== 32'h13 || le_busy !== 1'b1 ||
          be_we !== 1'b1 || be_addr !== 11'(i)) begin
        if (bad == 0) begin
          first_i = i;
          first_v = {le_addr, le_wdata};
        end
        bad++;
      end
      clear_req = (i == 1000);
      rx_valid  = (i >= 500 && i < 504);
      rx_byte   = SYNC_B;
      @(negedge clk);
    end
    clear_req = 1'b0;
    rx_valid  = 1'b0;
    n_checks++;
    if (bad != 0)
      $display("FAIL clear_fill: %0d bad cycles, first at %0d addr=%h data=%h, required addr=%h data=00000013 we=1 busy=1",
               bad, first_i, first_v[42:32], first_v[31:0], 11'(first_i));
    else n_pass++;
    n_checks++;
    if (le_busy !== 1'b0 || le_we !== 1'b0)
      $display("FAIL clear_end: busy=%b we=%b required 0 0", le_busy, le_we);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_timeout();
    logic [31:0] t;
    logic [7:0] fr[8];
    fr = '{SYNC_B, 8'h20, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    le_q.delete();
    for (int i = 0; i < 8; i++) send_byte(fr[i], t);
    idle(95);
    n_checks++;
    if (le_eto !== 1'b0 || le_busy !== 1'b1)
      $display("FAIL timeout_early: err_timeout=%b busy=%b required 0 1", le_eto, le_busy);
    else n_pass++;
    idle(10);
    n_checks++;
    if (le_eto !== 1'b1 || le_busy !== 1'b0 || le_done !== 1'b0 || le_q.size() != 0)
      $display("FAIL timeout_abort: err_timeout=%b busy=%b done=%b writes=%0d required 1 0 0 0",
               le_eto, le_busy, le_done, le_q.size());
    else n_pass++;
    run_frame($urandom_range(0, 2000), 3, 1'b0, 2, "after_timeout");
  endtask

  task automatic test_abort();
    logic [31:0] t;
    logic [7:0] fr[8];
    fr = '{SYNC_B, 8'h00, 8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    le_q.delete();
    be_q.delete();
    for (int i = 0; i < 8; i++) send_byte(fr[i], t);
    @(negedge clk);
    rx_valid = 1'b1; rx_byte = 8'h44; enable = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0; enable = 1'b1;
    n_checks++;
    if ({le_busy, le_done, le_ecs, le_elen, le_eto} !== 5'd0)
      $display("FAIL abort_flags: busy/done/csum/len/tmo=%b required 00000",
               {le_busy, le_done, le_ecs, le_elen, le_eto});
    else n_pass++;
    idle(2);
    #1;
    n_checks++;
    if (le_q.size() != 0 || be_q.size() != 0)
      $display("FAIL abort_nowrite: writes le=%0d be=%0d required 0", le_q.size(), be_q.size());
    else n_pass++;
    pay_q = '{8'h00, 8'h50, 8'h00, 8'h93};
    run_frame($urandom_range(0, 2047), 1, 1'b0, 1, "be_frame");
    pay_q.delete();
    n_checks++;
    if (be_q.size() != 1 || be_q[0].d !== 32'h00500093 || le_q.size() != 1 || le_q[0].d !== 32'h93005000)
      $display("FAIL be_word: be=%h le=%h required be=00500093 le=93005000",
               (be_q.size() > 0) ? be_q[0].d : 32'h0, (le_q.size() > 0) ? le_q[0].d : 32'h0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_frame($urandom_range(0, 1000), 4, 1'b0, 0, "b2b");
    run_frame($urandom_range(0, 1000), 3, 1'b1, 0, "b2b_bad");
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++)
      run_frame($urandom_range(0, DEPTH - 1), $urandom_range(0, 6),
                ($urandom_range(0, 3) == 0), $urandom_range(0, 3), "random");
  endtask

  initial begin
    test_reset();
    test_spec_frame();
    test_len();
    test_clear();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/im_uart_loader.md
# im_uart_loader

Parametrised instruction-memory loader that follows the single-purpose ROM writer. It turns a stream of UART bytes into framed, checksummed, block-addressed word writes to the instruction memory. It also provides a hardware fill of the whole memory with a configurable value. It sits between the UART receiver and the write port of the instruction ROM, and it runs on the fast board clock while the CPU clock is gated off.

## Interface
- DATA_W, 32, memory word width; must be a multiple of 8 (BYTES = DATA_W/8).
- ADDR_W, 11, memory word-address width.
- DEPTH, 2048, number of memory words; DEPTH ≤ 2^ADDR_W.
- SYNC, 8'hA5, frame start byte.
- FILL_VAL, 32'h00000013, word written by a clear operation (RISC-V nop).
- BIG_ENDIAN, 0, byte order inside a data word: 0 = first byte to bits [7:0]; 1 = first byte to MSB.
- TIMEOUT, 1000000, maximum clk cycles between bytes inside a frame.
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- enable  in  1  loader may accept frames or clears; low aborts any activity.
- clear_req  in  1  single-cycle request to fill memory with FILL_VAL.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid in that cycle.
- rx_byte  in  8  received byte.
- mem_we  out  1  write strobe to the instruction memory.
- mem_addr  out  ADDR_W  word write address.
- mem_wdata  out  DATA_W  write data.
- busy  out  1  a frame or clear is in progress.
- done  out  1  sticky; the last frame completed with a good checksum.
- err_csum  out  1  sticky; the last frame had a checksum mismatch.
- err_len  out  1  sticky; the last frame had an illegal count or range.
- err_timeout  out  1  sticky; the last frame stalled longer than TIMEOUT.
- words_loaded  out  ADDR_W+1  number of words written by the current or last frame.

## Operation
- **Frame format:** SYNC, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, then N×BYTES data bytes, then CSUM.
  - Only the low ADDR_W bits of the address are used.
  - The frame is valid when the 8-bit sum of every byte after SYNC, including CSUM, is 0 mod 256.
- **States:** IDLE → A_LO → A_HI → C_LO → C_HI → DATA → CHK → IDLE. A separate CLEAR state handles the fill.
- **IDLE:**
  - rx_byte == SYNC with enable high → A_LO. This clears done and all err_* flags and zeroes words_loaded.
  - Any other byte is ignored.
- **Count check in C_HI:**
  - If N == 0 or base+N > DEPTH, set err_len and go to IDLE. No writes occur.
- **DATA:**
  - Bytes are assembled per BIG_ENDIAN.
  - On the last byte of each word: write the word at base+k and increment words_loaded.
  - After N words → CHK.
- **CHK:**
  - Sum == 0 → set done. Otherwise set err_csum.
  - Words already written are not rolled back.
- **Timeout:** in any frame state, TIMEOUT cycles without rx_valid → set err_timeout and go to IDLE.
- **CLEAR:**
  - Entered when clear_req is high, enable is high and the state is IDLE. This clears all flags.
  - Writes FILL_VAL to addresses 0..DEPTH-1, one per cycle, then returns to IDLE.
  - FILL_VAL is truncated or zero-extended to DATA_W.
- **enable low, any state:** next state is IDLE, no flags are set, and a write in flight is suppressed.
- **Ignored inputs:**
  - clear_req outside IDLE.
  - rx_valid during CLEAR.
  - rx_valid and clear_req together in IDLE: clear_req wins and the byte is dropped.

## Timing
- **Reset values:** state IDLE; mem_we 0; mem_addr 0; mem_wdata 0; busy 0; done 0; err_* 0; words_loaded 0.
- **Outputs are registered.**
- **Word write:** mem_we is high for exactly one cycle, in the cycle after the rx_valid of the word's final byte. mem_addr and mem_wdata are valid in that same cycle.
- **busy:**
  - Rises in the cycle after SYNC is accepted.
  - Falls in the cycle after CHK, or on the error or abort transition.
  - done or err_* become visible in the same cycle that busy falls.
- **Clear:**
  - busy and the first mem_we (address 0) appear in the cycle after clear_req.
  - mem_we stays high for DEPTH consecutive cycles.
  - busy falls in the cycle after the write to address DEPTH-1.
- **Back-to-back bytes:** bytes may arrive on consecutive cycles, so the design must have no per-byte dead cycle.
- **Timeout counter:** restarts on every accepted byte. The abort occurs when the count reaches TIMEOUT.
- **Address:** base+k never wraps, because the range check guarantees it stays below DEPTH.

## Test plan
- Frame A5 10 00 02 00, then words 0x00500093 and 0x00100113 (LE bytes), then a correct CSUM. Required: two mem_we pulses, at addr 0x010 and 0x011, with those exact data. done=1, busy=0, words_loaded=2.
- The same frame with CSUM+1. Required: both words written, err_csum=1, done=0.
- Count 0, or base 0x7FF with N=2 (DEPTH 2048). Required: err_len=1 in the cycle after CNT_HI, no mem_we.
- clear_req in IDLE. Required: 2048 consecutive mem_we with addresses 0..2047 and data 0x00000013. busy high for 2048 cycles. A second clear_req mid-fill is ignored.
- Frame stalls after 3 data bytes with TIMEOUT=100. Required: err_timeout=1 after 100 idle cycles, no partial write, IDLE accepts a new SYNC.
- enable dropped mid-DATA, then a frame sent with BIG_ENDIAN=1 and bytes 00 50 00 93. Required: the abort gives no flags and no writes; the following frame writes 0x00500093.
